// File: rtl/ctrl_pkg.sv
// Shared decode constants for the pipelined decode controller: field positions,
// opcode values, ALU select codes and the NOP instruction word.
package ctrl_pkg;

    localparam int NREG = 32;
    localparam int IW   = 32;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    localparam logic [5:0]    OP_RTYPE   = 6'b000000;
    localparam logic [2:0]    OP_IMM_PFX = 3'b001;
    localparam logic [IW-1:0] NOP_IR     = 32'h0;

    typedef enum logic [2:0] {
        S_XOR  = 3'b000,
        S_XNOR = 3'b001,
        S_ADD  = 3'b010,
        S_SUB  = 3'b011,
        S_OR   = 3'b100,
        S_NOR  = 3'b101,
        S_AND  = 3'b110,
        S_ONES = 3'b111
    } alu_sel_e;

    function automatic logic [IW-1:0] signExt16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/onehot5to32.sv
// Converts a 5-bit register index into a 32-bit one-hot select.
module onehot5to32 (
    input  logic [4:0]  idx_i,
    output logic [31:0] onehot_o
);

    assign onehot_o = 32'h1 << idx_i;

endmodule

// File: rtl/pipe_decode_ctrl.sv
// Pipelined decode controller: IF/ID, ID/EX and EX/MEM control registers driving
// regfile selects and ALU controls. Define HAZARD_STALL_EN to enable RAW stall logic.
module pipe_decode_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ibus,
    output logic [31:0] Aselect,
    output logic [31:0] Bselect,
    output logic        Imm,
    output logic [31:0] immed,
    output logic [2:0]  S,
    output logic        Cin,
    output logic [31:0] Dselect,
    output logic        stall
);

    logic [IW-1:0] ir_q;
    logic [2:0]    s_q;
    logic          cin_q;
    logic [4:0]    exDest_q;
    logic [4:0]    memDest_q;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] fn;
    logic       isRtype;
    logic       isImm;

    logic [4:0] aIdx;
    logic [4:0] bIdx;
    logic [4:0] dest_d;
    logic [2:0] s_d;
    logic       cin_d;
    logic       valid_d;

    // Shift-amount bits are never used by this datapath.
    logic unusedShamt;
    assign unusedShamt = ^ir_q[10:6];

    assign op = ir_q[OP_HI:OP_LO];
    assign rs = ir_q[RS_HI:RS_LO];
    assign rt = ir_q[RT_HI:RT_LO];
    assign rd = ir_q[RD_HI:RD_LO];
    assign fn = ir_q[FN_HI:FN_LO];

    assign isRtype = (op == OP_RTYPE) && (fn[5:3] == 3'b000);
    assign isImm   = (op[5:3] == OP_IMM_PFX);

    always_comb begin
        aIdx    = 5'd0;
        bIdx    = 5'd0;
        dest_d  = 5'd0;
        s_d     = S_XOR;
        valid_d = 1'b0;
        if (isRtype) begin
            aIdx    = rs;
            bIdx    = rt;
            dest_d  = rd;
            s_d     = fn[2:0];
            valid_d = 1'b1;
        end else if (isImm) begin
            aIdx    = rs;
            dest_d  = rt;
            s_d     = op[2:0];
            valid_d = 1'b1;
        end
        cin_d = (s_d == S_SUB);
    end

    assign Imm   = isImm;
    assign immed = signExt16(ir_q[15:0]);

`ifdef HAZARD_STALL_EN
    logic exValid_q;

    // Writes complete on the falling edge of MEM, so only the EX-stage dest can collide.
    assign stall = exValid_q && (exDest_q != 5'd0) &&
                   ((exDest_q == rs) || ((op == OP_RTYPE) && (exDest_q == rt)));

    always_ff @(posedge clk) begin
        if (reset || stall) begin
            exValid_q <= 1'b0;
        end else begin
            exValid_q <= valid_d;
        end
    end
`else
    logic unusedValid;
    assign unusedValid = valid_d;
    assign stall       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= NOP_IR;
        end else if (!stall) begin
            ir_q <= ibus;
        end
    end

    // A stall turns the instruction entering EX into a bubble while IR holds.
    always_ff @(posedge clk) begin
        if (reset || stall) begin
            s_q      <= S_XOR;
            cin_q    <= 1'b0;
            exDest_q <= 5'd0;
        end else begin
            s_q      <= s_d;
            cin_q    <= cin_d;
            exDest_q <= dest_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            memDest_q <= 5'd0;
        end else begin
            memDest_q <= exDest_q;
        end
    end

    assign S   = s_q;
    assign Cin = cin_q;

    onehot5to32 uASel (.idx_i(aIdx),      .onehot_o(Aselect));
    onehot5to32 uBSel (.idx_i(bIdx),      .onehot_o(Bselect));
    onehot5to32 uDSel (.idx_i(memDest_q), .onehot_o(Dselect));

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed testbench for pipe_decode_ctrl; hazard checks apply when HAZARD_STALL_EN is defined.
module tb_pipe_decode_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] ibus;
    logic [31:0] Aselect;
    logic [31:0] Bselect;
    logic        Imm;
    logic [31:0] immed;
    logic [2:0]  S;
    logic        Cin;
    logic [31:0] Dselect;
    logic        stall;

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [31:0] I_NOP     = 32'h0;
    localparam logic [31:0] I_SUB     = {6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'b000011};
    localparam logic [31:0] I_ORI     = {6'b001100, 5'd7, 5'd9, 16'hFFF0};
    localparam logic [31:0] I_ILLEGAL = {6'b111111, 5'd3, 5'd4, 5'd5, 5'd0, 6'b000011};
    localparam logic [31:0] I_BADFN   = {6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'b001000};
    localparam logic [31:0] I_ADD5    = {6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'b000010};
    localparam logic [31:0] I_XOR6    = {6'd0, 5'd5, 5'd1, 5'd6, 5'd0, 6'b000000};
    localparam logic [31:0] I_ADD0    = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b000010};
    localparam logic [31:0] I_ADD3R0  = {6'd0, 5'd0, 5'd0, 5'd3, 5'd0, 6'b000010};

    pipe_decode_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .ibus    (ibus),
        .Aselect (Aselect),
        .Bselect (Bselect),
        .Imm     (Imm),
        .immed   (immed),
        .S       (S),
        .Cin     (Cin),
        .Dselect (Dselect),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an instruction, let one rising edge pass, then settle on the falling edge.
    task automatic applyStimulus(input logic [31:0] instr);
        ibus = instr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        ibus  = I_NOP;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_A",     Aselect, 32'h1);
        checkOutput("rst_B",     Bselect, 32'h1);
        checkOutput("rst_D",     Dselect, 32'h1);
        checkOutput("rst_S",     {29'd0, S}, 32'd0);
        checkOutput("rst_Cin",   {31'd0, Cin}, 32'd0);
        checkOutput("rst_Imm",   {31'd0, Imm}, 32'd0);
        checkOutput("rst_immed", immed, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(I_NOP);
            checkOutput("rst_D_idle", Dselect, 32'h1);
        end

        // R-type SUB r5 <- r3 - r4
        applyStimulus(I_SUB);
        checkOutput("sub_A",   Aselect, 32'h1 << 3);
        checkOutput("sub_B",   Bselect, 32'h1 << 4);
        checkOutput("sub_Imm", {31'd0, Imm}, 32'd0);
        applyStimulus(I_NOP);
        checkOutput("sub_S",   {29'd0, S}, 32'd3);
        checkOutput("sub_Cin", {31'd0, Cin}, 32'd1);
        checkOutput("sub_D_early", Dselect, 32'h1);
        applyStimulus(I_NOP);
        checkOutput("sub_D",   Dselect, 32'h1 << 5);
        checkOutput("sub_S_after", {29'd0, S}, 32'd0);

        // I-type OR r9 <- r7 | sext(FFF0)
        applyStimulus(I_ORI);
        checkOutput("ori_A",     Aselect, 32'h1 << 7);
        checkOutput("ori_B",     Bselect, 32'h1);
        checkOutput("ori_Imm",   {31'd0, Imm}, 32'd1);
        checkOutput("ori_immed", immed, 32'hFFFFFFF0);
        applyStimulus(I_NOP);
        checkOutput("ori_S",   {29'd0, S}, 32'd4);
        checkOutput("ori_Cin", {31'd0, Cin}, 32'd0);
        applyStimulus(I_NOP);
        checkOutput("ori_D",   Dselect, 32'h1 << 9);

        // Illegal opcode and R-type with nonzero fn[5:3] both act as NOP
        applyStimulus(I_ILLEGAL);
        checkOutput("ill_A", Aselect, 32'h1);
        checkOutput("ill_B", Bselect, 32'h1);
        applyStimulus(I_BADFN);
        checkOutput("ill_S",   {29'd0, S}, 32'd0);
        checkOutput("ill_Cin", {31'd0, Cin}, 32'd0);
        checkOutput("badfn_A", Aselect, 32'h1);
        applyStimulus(I_NOP);
        checkOutput("ill_D",   Dselect, 32'h1);
        checkOutput("badfn_S", {29'd0, S}, 32'd0);
        applyStimulus(I_NOP);
        checkOutput("badfn_D", Dselect, 32'h1);

        // Reset mid-stream discards the in-flight SUB
        applyStimulus(I_SUB);
        reset = 1'b1;
        applyStimulus(I_NOP);
        reset = 1'b0;
        checkOutput("mrst_S", {29'd0, S}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mrst_D", Dselect, 32'h1);
            applyStimulus(I_NOP);
        end

        // ADD r5 <- r3,r4 followed by dependent XOR r6 <- r5,r1
        applyStimulus(I_ADD5);
        checkOutput("haz_nostall0", {31'd0, stall}, 32'd0);
        applyStimulus(I_XOR6);
        checkOutput("haz_A", Aselect, 32'h1 << 5);
`ifdef HAZARD_STALL_EN
        checkOutput("haz_stall",  {31'd0, stall}, 32'd1);
        checkOutput("haz_D0",     Dselect, 32'h1);
        applyStimulus(I_XOR6);
        checkOutput("haz_stall1", {31'd0, stall}, 32'd0);
        checkOutput("haz_A_hold", Aselect, 32'h1 << 5);
        checkOutput("haz_D1",     Dselect, 32'h1 << 5);
        applyStimulus(I_NOP);
        checkOutput("haz_D2",     Dselect, 32'h1);
        checkOutput("haz_S_xor",  {29'd0, S}, 32'd0);
        applyStimulus(I_NOP);
        checkOutput("haz_D3",     Dselect, 32'h1 << 6);
`else
        checkOutput("nohaz_stall", {31'd0, stall}, 32'd0);
        applyStimulus(I_NOP);
        checkOutput("nohaz_D1",    Dselect, 32'h1 << 5);
        checkOutput("nohaz_S_xor", {29'd0, S}, 32'd0);
        applyStimulus(I_NOP);
        checkOutput("nohaz_D2",    Dselect, 32'h1 << 6);
`endif
        applyStimulus(I_NOP);
        applyStimulus(I_NOP);

        // Writes to r0 never create a dependency
        applyStimulus(I_ADD0);
        checkOutput("r0_stall0", {31'd0, stall}, 32'd0);
        applyStimulus(I_ADD3R0);
        checkOutput("r0_stall1", {31'd0, stall}, 32'd0);
        checkOutput("r0_A",      Aselect, 32'h1);
        applyStimulus(I_NOP);
        checkOutput("r0_D",      Dselect, 32'h1);
        checkOutput("r0_S",      {29'd0, S}, 32'd2);
        applyStimulus(I_NOP);
        checkOutput("r0_D3",     Dselect, 32'h1 << 3);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
